// File: rtl/layerio_writer_if.sv
// layerio_writer_if: control, stream and FIFO-write signals of layerio_writer
interface layerio_writer_if #(
  parameter int DATA_W = 256,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [CNT_W-1:0]  size_w;
  logic [CNT_W-1:0]  total_vecs;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wrreq;
  logic [DATA_W-1:0] d_value;
  logic              d_info_valid;
  logic              d_info_last_w;
  logic              d_info_last;
  logic              half_full;
  logic              full;
  logic              busy;
  logic              done_writing;
  logic              wrote_layer;
  logic              overflow_err;
  modport master (
    output start, size_w, total_vecs, in_valid, in_data, half_full, full,
    input  in_ready, wrreq, d_value, d_info_valid, d_info_last_w, d_info_last,
           busy, done_writing, wrote_layer, overflow_err
  );
  modport slave (
    input  start, size_w, total_vecs, in_valid, in_data, half_full, full,
    output in_ready, wrreq, d_value, d_info_valid, d_info_last_w, d_info_last,
           busy, done_writing, wrote_layer, overflow_err
  );
endinterface

// File: rtl/layerio_writer.sv
// layerio_writer: streams one layer of result vectors into the layer-IO FIFO with row/layer tags
module layerio_writer #(
  parameter int DATA_W = 256,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic reset,
  layerio_writer_if.slave io
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] size_q, size_d, total_q, total_d, w_q, w_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic fin_q, fin_d, wr_q, wr_d, lw_q, lw_d, l_q, l_d, wl_q, wl_d, ovf_q, ovf_d;
  logic go, xfer, last, last_w;
  assign io.in_ready      = (state_q == WRITE) && !io.half_full && !fin_q;
  assign io.wrreq         = wr_q;
  assign io.d_value       = val_q;
  assign io.d_info_valid  = wr_q;
  assign io.d_info_last_w = lw_q;
  assign io.d_info_last   = l_q;
  assign io.busy          = state_q != IDLE;
  assign io.done_writing  = state_q == DONE;
  assign io.wrote_layer   = wl_q;
  assign io.overflow_err  = ovf_q;
  always_comb begin
    go      = (state_q == IDLE) && io.start;
    xfer    = io.in_valid && io.in_ready;
    last    = cnt_q == total_q - CNT_W'(1);
    last_w  = last || (w_q == size_q - CNT_W'(1));
    state_d = state_q;
    size_d  = size_q;
    total_d = total_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    if (go) begin
      size_d  = io.size_w;
      total_d = io.total_vecs;
      w_d     = '0;
      cnt_d   = '0;
      fin_d   = 1'b0;
      state_d = (io.size_w == '0 || io.total_vecs == '0) ? DONE : WRITE;
    end
    if (xfer) begin
      w_d   = last_w ? '0 : w_q + CNT_W'(1);
      cnt_d = cnt_q + CNT_W'(1);
      fin_d = last;
    end
    if (state_q == WRITE && wr_q && l_q) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
    // output stage is registered so the FIFO sees one write per transfer, one cycle later
    wr_d  = xfer;
    val_d = xfer ? io.in_data : '0;
    lw_d  = xfer && last_w;
    l_d   = xfer && last;
    wl_d  = (state_d == DONE) || (wl_q && !go);
    ovf_d = ovf_q || (wr_q && io.full);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      size_q  <= '0;
      total_q <= '0;
      w_q     <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      wr_q    <= 1'b0;
      val_q   <= '0;
      lw_q    <= 1'b0;
      l_q     <= 1'b0;
      wl_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      total_q <= total_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      wr_q    <= wr_d;
      val_q   <= val_d;
      lw_q    <= lw_d;
      l_q     <= l_d;
      wl_q    <= wl_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_layerio_writer.sv
// tb_layerio_writer: directed self-checking bench for layerio_writer
module tb_layerio_writer;
  localparam int DW = 32;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_wr = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  logic [DW-1:0] wd [64];
  logic wlw [64];
  logic wl [64];
  int wc [64];
  layerio_writer_if #(.DATA_W(DW), .CNT_W(CW)) ifc ();
  layerio_writer #(.DATA_W(DW), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .io(ifc.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ifc.wrreq && n_wr < 64) begin
      wd[n_wr]  = ifc.d_value;
      wlw[n_wr] = ifc.d_info_last_w;
      wl[n_wr]  = ifc.d_info_last;
      wc[n_wr]  = cyc;
      n_wr      = n_wr + 1;
    end
    if (ifc.done_writing) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_start(input int s, input int t);
    ifc.start = 1'b1;
    ifc.size_w = CW'(s);
    ifc.total_vecs = CW'(t);
    tick();
    ifc.start = 1'b0;
  endtask
  task automatic feed(input int n, input int base, input int hf_at, input int hf_len, input int st_at);
    int k = 0;
    int c = 0;
    while (k < n && c < 200) begin
      ifc.half_full = (c >= hf_at && c < hf_at + hf_len);
      ifc.start = (c == st_at);
      ifc.size_w = (c == st_at) ? CW'(1) : ifc.size_w;
      ifc.total_vecs = (c == st_at) ? CW'(9) : ifc.total_vecs;
      ifc.in_valid = 1'b1;
      ifc.in_data = DW'(base + k);
      @(negedge clk);
      if (ifc.half_full) chk("in_ready_under_half_full", ifc.in_ready, 0);
      if (ifc.in_ready) k++;
      tick();
      c++;
    end
    if (c >= 200) chk("feed_timeout", c, 0);
    ifc.in_valid = 1'b0;
    ifc.half_full = 1'b0;
    ifc.start = 1'b0;
  endtask
  task automatic chk_writes(input int b, input int n, input int size, input int dbase, input bit consec);
    chk("write_count", n_wr - b, n);
    for (int i = 0; i < n && b + i < 64; i++) begin
      chk($sformatf("data[%0d]", i), wd[b+i], DW'(dbase + i));
      chk($sformatf("last_w[%0d]", i), wlw[b+i], ((i % size) == size - 1) || (i == n - 1));
      chk($sformatf("last[%0d]", i), wl[b+i], i == n - 1);
      if (consec) chk($sformatf("consecutive[%0d]", i), wc[b+i] - wc[b], i);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wrreq"}, ifc.wrreq, 0);
    chk({tag, "_d_value"}, ifc.d_value, 0);
    chk({tag, "_tags"}, {ifc.d_info_valid, ifc.d_info_last_w, ifc.d_info_last}, 0);
    chk({tag, "_busy"}, ifc.busy, 0);
    chk({tag, "_done"}, ifc.done_writing, 0);
    chk({tag, "_in_ready"}, ifc.in_ready, 0);
  endtask
  initial begin
    int b, d0;
    reset = 1'b1;
    ifc.start = 1'b0; ifc.size_w = '0; ifc.total_vecs = '0;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.half_full = 1'b0; ifc.full = 1'b0;
    tick(2);
    chk_idle_outputs("reset");
    chk("reset_wrote_layer", ifc.wrote_layer, 0);
    chk("reset_overflow", ifc.overflow_err, 0);
    reset = 1'b0;
    tick();
    // 3 vectors per row, 6 per layer, continuous input
    b = n_wr;
    do_start(3, 6);
    chk("t1_busy", ifc.busy, 1);
    feed(6, 'h100, 99, 0, -1);
    tick(3);
    chk_writes(b, 6, 3, 'h100, 1);
    chk("t1_done_after_last", done_cyc - wc[b+5], 1);
    chk("t1_done_count", done_cnt, 1);
    chk("t1_wrote_layer", ifc.wrote_layer, 1);
    chk_idle_outputs("t1_end");
    // half_full held for 4 cycles mid-layer
    b = n_wr;
    do_start(4, 8);
    feed(8, 'h200, 3, 4, -1);
    tick(3);
    chk_writes(b, 8, 4, 'h200, 0);
    chk("t2_done_count", done_cnt, 2);
    // zero-length layer
    b = n_wr;
    do_start(2, 0);
    chk("t3_done", ifc.done_writing, 1);
    chk("t3_busy", ifc.busy, 1);
    chk("t3_wrote_layer", ifc.wrote_layer, 1);
    tick();
    chk("t3_done_pulse_ends", ifc.done_writing, 0);
    chk("t3_wrote_layer_held", ifc.wrote_layer, 1);
    tick(2);
    chk("t3_no_writes", n_wr - b, 0);
    // second start during WRITE must be ignored
    b = n_wr;
    do_start(2, 4);
    chk("t4_wrote_layer_cleared", ifc.wrote_layer, 0);
    feed(4, 'h300, 99, 0, 1);
    ifc.in_valid = 1'b1;
    ifc.in_data = 'hdead;
    tick(5);
    ifc.in_valid = 1'b0;
    chk_writes(b, 4, 2, 'h300, 1);
    chk("t4_idle", ifc.busy, 0);
    // writes into a full FIFO flag a sticky overflow
    chk("t5_no_overflow_yet", ifc.overflow_err, 0);
    b = n_wr;
    ifc.full = 1'b1;
    do_start(1, 2);
    feed(2, 'h400, 99, 0, -1);
    tick(2);
    ifc.full = 1'b0;
    chk_writes(b, 2, 1, 'h400, 1);
    chk("t5_overflow", ifc.overflow_err, 1);
    tick(4);
    chk("t5_overflow_sticky", ifc.overflow_err, 1);
    // reset after 2 of 5 transfers
    b = n_wr;
    d0 = done_cnt;
    do_start(5, 5);
    feed(2, 'h500, 99, 0, -1);
    reset = 1'b1;
    tick();
    chk_idle_outputs("t6_reset");
    chk("t6_reset_overflow", ifc.overflow_err, 0);
    chk("t6_reset_wrote_layer", ifc.wrote_layer, 0);
    reset = 1'b0;
    tick(3);
    chk("t6_partial_writes", n_wr - b, 2);
    chk("t6_no_done", done_cnt, d0);
    b = n_wr;
    do_start(5, 5);
    feed(5, 'h600, 99, 0, -1);
    tick(3);
    chk_writes(b, 5, 5, 'h600, 1);
    chk("t6_done_count", done_cnt, d0 + 1);
    chk("t6_wrote_layer", ifc.wrote_layer, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/layerio_writer.md
LAYERIO_WRITER -- requirements
Module: layerio_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 256: width of one layer-IO vector.
REQ-002 SHALL have parameter CNT_W, default 16: width of the layer-geometry counters.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that starts one layer write.
REQ-006 SHALL have port size_w, input, CNT_W bits: vectors per output row; sampled on accepted start.
REQ-007 SHALL have port total_vecs, input, CNT_W bits: vectors in the layer; sampled on accepted start.
REQ-008 SHALL have port in_valid, input, 1 bit: upstream result vector valid.
REQ-009 SHALL have port in_data, input, DATA_W bits: upstream result vector.
REQ-010 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-011 SHALL have port wrreq, output, 1 bit: write strobe into layer-IO memory FIFO.
REQ-012 SHALL have port d_value, output, DATA_W bits: write data.
REQ-013 SHALL have port d_info_valid, output, 1 bit: info tag, set on every write.
REQ-014 SHALL have port d_info_last_w, output, 1 bit: info tag, set on the last vector of a row.
REQ-015 SHALL have port d_info_last, output, 1 bit: info tag, set on the last vector of the layer.
REQ-016 SHALL have port half_full, input, 1 bit: FIFO backpressure.
REQ-017 SHALL have port full, input, 1 bit: FIFO full.
REQ-018 SHALL have port busy, output, 1 bit: a layer is in progress.
REQ-019 SHALL have port done_writing, output, 1 bit: one-cycle pulse when the layer completes.
REQ-020 SHALL have port wrote_layer, output, 1 bit: level, set at completion, cleared by next accepted start.
REQ-021 SHALL have port overflow_err, output, 1 bit: sticky error flag.

Function
REQ-022 SHALL implement FSM states IDLE, WRITE, DONE.
REQ-023 SHALL transition IDLE->WRITE on start when size_w!=0 and total_vecs!=0, latching both inputs and clearing the counters.
REQ-024 SHALL transition IDLE->DONE on start when size_w==0 or total_vecs==0; no write SHALL be issued.
REQ-025 SHALL ignore start in WRITE or DONE (no relatch, no counter disturbance).
REQ-026 SHALL drive in_ready = (state==WRITE) && !half_full && !final_accepted, where final_accepted means the total_vecs-th transfer has occurred.
REQ-027 SHALL define a transfer as in_valid && in_ready in the same cycle.
REQ-028 SHALL issue wrreq exactly one cycle after each transfer (registered output stage), with d_value = the transferred in_data; wrreq SHALL be 0 otherwise.
REQ-029 SHALL keep a w counter of CNT_W bits that increments per transfer and wraps to 0 after size_w-1; d_info_last_w SHALL be 1 on the write whose w count equals size_w-1.
REQ-030 SHALL keep a total counter of CNT_W bits that increments per transfer; d_info_last SHALL be 1 on the write whose count equals total_vecs-1, which also forces d_info_last_w=1.
REQ-031 SHALL transition WRITE->DONE in the cycle the last write (d_info_last=1) is issued.
REQ-032 SHALL spend exactly one cycle in DONE, asserting done_writing for that cycle, setting wrote_layer, and returning to IDLE.
REQ-033 SHALL drive busy=1 in WRITE and DONE, and 0 in IDLE.
REQ-034 SHALL set overflow_err when wrreq=1 and full=1 in the same cycle; the write SHALL still be issued and overflow_err SHALL hold until reset.
REQ-035 SHALL have in_data ignored when in_ready=0; in_valid without in_ready SHALL have no effect.
REQ-036 SHALL hold d_value and all info tags at 0 when wrreq=0.

Reset
REQ-037 SHALL place the FSM in IDLE and zero all counters and latched parameters on reset.
REQ-038 SHALL drive in_ready, wrreq, d_value, all d_info tags, busy, done_writing, wrote_layer and overflow_err to 0 on reset.
REQ-039 SHALL, on reset during WRITE, drop the pending output stage: no wrreq in the cycle after reset and no done_writing.

Verification
REQ-040 Bench SHALL cover: start with size_w=3, total_vecs=6, continuous in_valid -> 6 wrreqs on consecutive cycles; last_w on writes 3 and 6; last on write 6; done_writing 1 cycle later; wrote_layer=1.
REQ-041 Bench SHALL cover: half_full held high for 4 cycles mid-layer -> in_ready=0 throughout; no lost or duplicated vectors; write order and data match the input.
REQ-042 Bench SHALL cover: start with total_vecs=0 -> no wrreq; done_writing the next cycle; wrote_layer=1.
REQ-043 Bench SHALL cover: second start pulse during WRITE -> ignored; write count is still total_vecs.
REQ-044 Bench SHALL cover: full forced high with wrreq=1 -> overflow_err=1 and stays 1 until reset.
REQ-045 Bench SHALL cover: reset asserted after 2 of 5 transfers -> all outputs 0 next cycle; a new start writes a full 5 vectors.
